audio_i2s_receiver: RTL and testbench

- Receive-side counterpart of the synth engine's I2S transmit path: deserialises a standard I2S stream (ADC, codec loopback or external source) into parallel left/right words.
- Block is slave-mode: the external codec/master drives iAUD_BCK and iAUD_LRCK; both are oversampled by the single system clock iCLK.
- Outputs a left/right sample pair plus a one-cycle valid strobe per frame, feeding the synth engine's audio-in and monitor path.

---
 rtl/audio_i2s_receiver_pkg.sv | 21 ++
 rtl/audio_i2s_receiver_input_sync.sv | 43 ++++
 rtl/audio_i2s_receiver.sv | 149 ++++++++++++++
 tb/tb_audio_i2s_receiver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_receiver_pkg.sv
// Shared audio definitions for the I2S receive and transmit paths.
package audio_i2s_receiver_pkg;

  // Default sample width, shared with audio_i2s_driver.
  localparam int AUDIO_DATA_WIDTH = 16;

  // Word-select polarity: LRCK low carries the left slot.
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  // One-hot bit placement used when filling a word MSB first.
  function automatic logic [AUDIO_DATA_WIDTH-1:0] place_bit(
    input logic                              bit_val,
    input logic [$clog2(AUDIO_DATA_WIDTH):0] pos
  );
    logic [AUDIO_DATA_WIDTH-1:0] word;
    word = {{(AUDIO_DATA_WIDTH-1){1'b0}}, bit_val};
    return word << pos;
  endfunction

endpackage

// File: rtl/audio_i2s_receiver_input_sync.sv
// Synchronises the asynchronous I2S pins into the system clock domain and
// flags the system-clock cycle in which a rising bit-clock edge is seen.
module i2s_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bck_i,
  input  logic lrck_i,
  input  logic data_i,
  output logic bck_rise_o,
  output logic lrck_o,
  output logic data_o
);

  logic [SYNC_STAGES-1:0] bck_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   bck_hist_q;

  // Shift each pin through its synchroniser chain; keep one bit-clock history flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bck_sync_q  <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bck_hist_q  <= 1'b0;
    end else begin
      bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], bck_i};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], data_i};
      bck_hist_q  <= bck_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge decode from flopped values only, so the strobe is glitch-free.
  always_comb begin
    bck_rise_o = bck_sync_q[SYNC_STAGES-1] & ~bck_hist_q;
    lrck_o     = lrck_sync_q[SYNC_STAGES-1];
    data_o     = data_sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/audio_i2s_receiver.sv
// Slave-mode I2S receiver: deserialises left/right slots into parallel words
// and presents each completed pair with a one-cycle valid strobe.
module audio_i2s_receiver
  import audio_i2s_receiver_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iAUD_BCK,
  input  logic                  iAUD_LRCK,
  input  logic                  iAUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] o_lsound_in,
  output logic [DATA_WIDTH-1:0] o_rsound_in,
  output logic                  o_valid,
  output logic                  o_short
);

  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_TOP  = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic bck_rise_s;
  logic lrck_s;
  logic data_s;

  logic                  synced_q,    synced_d;
  logic                  have_left_q, have_left_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic [CW-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0] lsound_q,    lsound_d;
  logic [DATA_WIDTH-1:0] rsound_q,    rsound_d;
  logic                  valid_q,     valid_d;
  logic                  short_q,     short_d;

  i2s_input_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_input_sync (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .bck_i      (iAUD_BCK),
    .lrck_i     (iAUD_LRCK),
    .data_i     (iAUD_ADCDAT),
    .bck_rise_o (bck_rise_s),
    .lrck_o     (lrck_s),
    .data_o     (data_s)
  );

  // Frame state: slot boundary handling, MSB-first capture and pair hand-off.
  always_comb begin
    synced_d    = synced_q;
    have_left_d = have_left_q;
    lrck_prev_d = lrck_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_left_d = hold_left_q;
    lsound_d    = lsound_q;
    rsound_d    = rsound_q;
    valid_d     = 1'b0;
    short_d     = short_q;

    if (bck_rise_s) begin
      lrck_prev_d = lrck_s;
      if (lrck_s != lrck_prev_q) begin
        // Word-select changed: close the slot that just ended, if we were locked.
        if (synced_q) begin
          case (lrck_prev_q)
            LRCK_LEFT: begin
              hold_left_d = shift_q;
              have_left_d = 1'b1;
            end
            LRCK_RIGHT: begin
              if (have_left_q) begin
                lsound_d = hold_left_q;
                rsound_d = shift_q;
                valid_d  = 1'b1;
              end else begin
                valid_d  = 1'b0;
              end
              have_left_d = 1'b0;
            end
            default: begin
              have_left_d = 1'b0;
            end
          endcase
          if (bit_cnt_q < CNT_FULL) begin
            short_d = 1'b1;
          end else begin
            short_d = short_q;
          end
        end else begin
          short_d = short_q;
        end
        // The bit on the boundary rise is the one-BCK I2S delay and is dropped.
        shift_d   = '0;
        bit_cnt_d = '0;
        synced_d  = 1'b1;
      end else if (synced_q && (bit_cnt_q < CNT_FULL)) begin
        shift_d   = shift_q | place_bit(data_s, CNT_TOP - bit_cnt_q);
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end else begin
        // Unlocked, or slot already full: surplus LSBs are truncated.
        shift_d = shift_q;
      end
    end else begin
      lrck_prev_d = lrck_prev_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      synced_q    <= 1'b0;
      have_left_q <= 1'b0;
      lrck_prev_q <= LRCK_LEFT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_left_q <= '0;
      lsound_q    <= '0;
      rsound_q    <= '0;
      valid_q     <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      synced_q    <= synced_d;
      have_left_q <= have_left_d;
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_left_q <= hold_left_d;
      lsound_q    <= lsound_d;
      rsound_q    <= rsound_d;
      valid_q     <= valid_d;
      short_q     <= short_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    o_lsound_in = lsound_q;
    o_rsound_in = rsound_q;
    o_valid     = valid_q;
    o_short     = short_q;
  end

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for audio_i2s_receiver. Each driven slot is one delay BCK
// period (word select already switched, junk data) followed by n data bits.
module tb_audio_i2s_receiver;

  logic        clk;
  logic        rst;
  logic        bck;
  logic        lrck;
  logic        dat;
  logic [15:0] lsound;
  logic [15:0] rsound;
  logic        valid;
  logic        short_flag;

  int checks = 0;
  int errors = 0;
  int half   = 4;

  logic [15:0] ql[$];
  logic [15:0] qr[$];
  logic [15:0] el_q[$];
  logic [15:0] er_q[$];

  typedef struct {
    logic [31:0] l_bits;
    logic [31:0] r_bits;
    int          nbits;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    logic        exp_short;
  } vec_t;

  vec_t vecs [0:4];

  audio_i2s_receiver dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iAUD_BCK    (bck),
    .iAUD_LRCK   (lrck),
    .iAUD_ADCDAT (dat),
    .o_lsound_in (lsound),
    .o_rsound_in (rsound),
    .o_valid     (valid),
    .o_short     (short_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every valid pair seen by the receiver.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      ql.push_back(lsound);
      qr.push_back(rsound);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bck_period(input logic lr, input logic d);
    bck  = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (half) @(negedge clk);
    bck = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  task automatic send_delay(input logic lr);
    bck_period(lr, 1'b1);
  endtask

  task automatic send_bits(input logic lr, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) bck_period(lr, bits[31-i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_delay(1'b0);
    send_bits(1'b0, l, n);
    send_delay(1'b1);
    send_bits(1'b1, r, n);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    ql.delete();
    qr.delete();
  endtask

  // Partial left slot (ignored) then an orphan right slot that locks the receiver.
  task automatic preamble();
    send_bits(1'b0, 32'h5555_0000, 5);
    send_delay(1'b1);
    send_bits(1'b1, 32'hFFFF_0000, 16);
  endtask

  task automatic check_one(input string name, input logic [15:0] el, input logic [15:0] er);
    logic [15:0] l;
    logic [15:0] r;
    chk({name, "_count"}, 32'(ql.size()), 32'd1);
    if (ql.size() > 0) begin
      l = ql.pop_front();
      r = qr.pop_front();
      chk({name, "_left"}, {16'd0, l}, {16'd0, el});
      chk({name, "_right"}, {16'd0, r}, {16'd0, er});
    end
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] r;
    rst  = 1'b1;
    bck  = 1'b0;
    lrck = 1'b0;
    dat  = 1'b0;
    vecs[0] = '{32'h8001_0000, 32'h7FFE_0000, 16, 16'h8001, 16'h7FFE, 1'b0};
    vecs[1] = '{32'hA5A5_FFFF, 32'h1234_0000, 32, 16'hA5A5, 16'h1234, 1'b0};
    vecs[2] = '{32'hFFFF_0000, 32'h0000_0000, 16, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{32'hFFF0_0000, 32'hABC0_0000, 12, 16'hFFF0, 16'hABC0, 1'b1};
    vecs[4] = '{32'h5A5A_0000, 32'hC3C3_0000, 16, 16'h5A5A, 16'hC3C3, 1'b1};

    @(negedge clk);
    do_reset(3);
    chk("reset_left",  {16'd0, lsound}, 32'd0);
    chk("reset_right", {16'd0, rsound}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_short", {31'd0, short_flag}, 32'd0);

    // Table-driven frames at BCK = iCLK/8; a row is checked once the next left slot opens.
    half = 4;
    preamble();
    for (int i = 0; i < 5; i++) begin
      send_delay(1'b0);
      repeat (8) @(negedge clk);
      if (i == 0) begin
        chk("orphan_right_no_valid", 32'(ql.size()), 32'd0);
        chk("orphan_right_short", {31'd0, short_flag}, 32'd0);
      end else begin
        check_one($sformatf("row%0d", i - 1), vecs[i-1].exp_l, vecs[i-1].exp_r);
        chk($sformatf("row%0d_short", i - 1), {31'd0, short_flag}, {31'd0, vecs[i-1].exp_short});
      end
      send_bits(1'b0, vecs[i].l_bits, vecs[i].nbits);
      send_delay(1'b1);
      send_bits(1'b1, vecs[i].r_bits, vecs[i].nbits);
    end
    send_delay(1'b0);
    repeat (8) @(negedge clk);
    check_one("row4", vecs[4].exp_l, vecs[4].exp_r);
    chk("row4_short", {31'd0, short_flag}, 32'd1);

    // BCK stopped: nothing changes and no spurious valid.
    repeat (60) @(negedge clk);
    chk("idle_no_valid", 32'(ql.size()), 32'd0);
    chk("idle_left_hold", {16'd0, lsound}, 32'h5A5A);
    chk("idle_right_hold", {16'd0, rsound}, 32'hC3C3);

    // Start-up: reset released in the middle of a right slot.
    rst  = 1'b1;
    send_delay(1'b1);
    send_bits(1'b1, 32'hF0F0_0000, 4);
    rst = 1'b0;
    ql.delete();
    qr.delete();
    send_bits(1'b1, 32'h0F0F_0000, 8);
    send_frame(32'h0001_0000, 32'h0002_0000, 16);
    send_frame(32'h0003_0000, 32'h0004_0000, 16);
    send_frame(32'h0005_0000, 32'h0006_0000, 16);
    send_delay(1'b0);
    repeat (8) @(negedge clk);
    chk("startup_count", 32'(ql.size()), 32'd3);
    for (int i = 0; i < 3 && ql.size() > 0; i++) begin
      l = ql.pop_front();
      r = qr.pop_front();
      chk($sformatf("startup%0d_left", i), {16'd0, l}, 32'(2 * i + 1));
      chk($sformatf("startup%0d_right", i), {16'd0, r}, 32'(2 * i + 2));
    end

    // Reset pulse during bit 7 of a left slot.
    do_reset(2);
    preamble();
    send_frame(32'h0A0A_0000, 32'h0B0B_0000, 16);
    send_delay(1'b0);
    repeat (4) @(negedge clk);
    check_one("prereset", 16'h0A0A, 16'h0B0B);
    send_bits(1'b0, 32'h1234_0000, 7);
    bck = 1'b0;
    dat = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_left",  {16'd0, lsound}, 32'd0);
    chk("midreset_right", {16'd0, rsound}, 32'd0);
    chk("midreset_valid", {31'd0, valid}, 32'd0);
    chk("midreset_short", {31'd0, short_flag}, 32'd0);
    ql.delete();
    qr.delete();
    @(negedge clk);
    bck = 1'b1;
    repeat (half) @(negedge clk);
    send_bits(1'b0, 32'h3400_0000, 8);
    send_delay(1'b1);
    send_bits(1'b1, 32'h9999_0000, 16);
    send_frame(32'h1111_0000, 32'h2222_0000, 16);
    send_delay(1'b0);
    repeat (8) @(negedge clk);
    check_one("postreset", 16'h1111, 16'h2222);
    chk("postreset_short", {31'd0, short_flag}, 32'd0);

    // Minimum clock ratio: BCK = iCLK/4, 100 random frames.
    half = 2;
    do_reset(2);
    preamble();
    el_q.delete();
    er_q.delete();
    for (int f = 0; f < 100; f++) begin
      l = 16'($urandom_range(0, 65535));
      r = 16'($urandom_range(0, 65535));
      el_q.push_back(l);
      er_q.push_back(r);
      send_frame({l, 16'h0000}, {r, 16'h0000}, 16);
    end
    send_delay(1'b0);
    repeat (8) @(negedge clk);
    chk("minratio_count", 32'(ql.size()), 32'd100);
    for (int f = 0; f < 100 && ql.size() > 0; f++) begin
      l = ql.pop_front();
      r = qr.pop_front();
      chk($sformatf("minratio%0d_left", f), {16'd0, l}, {16'd0, el_q[f]});
      chk($sformatf("minratio%0d_right", f), {16'd0, r}, {16'd0, er_q[f]});
    end
    chk("minratio_short", {31'd0, short_flag}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
